// File: rtl/ps2_host_tx_pkg.sv
// Shared constants for the PS/2 host transmitter: FSM encodings, register
// offsets and status bit positions.
package ps2_host_tx_pkg;

    typedef logic [2:0] state_t;

    localparam state_t IDLE         = 3'd0;
    localparam state_t INHIBIT      = 3'd1;
    localparam state_t START        = 3'd2;
    localparam state_t SHIFT        = 3'd3;
    localparam state_t ACK          = 3'd4;
    localparam state_t WAIT_RELEASE = 3'd5;

    localparam logic [15:0] REG_TX_DATA = 16'h0000;
    localparam logic [15:0] REG_STATUS  = 16'h0004;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_NAK     = 1;
    localparam int STAT_TIMEOUT = 2;
    localparam int STAT_OVERRUN = 3;

    // Position of this block in the system interrupt_req vector.
    localparam int IRQ_PS2_TX = 5;

endpackage

// File: rtl/io_bus_interface.sv
// Processor I/O bus shared by the UART, SPI, PS/2 and timer peripherals.
interface io_bus_interface;

    logic        write_en;
    logic        read_en;
    logic [15:0] adress;
    logic [31:0] write_data;
    logic [31:0] read_data;

    modport master (output write_en, output read_en, output adress, output write_data, input read_data);
    modport slave  (input write_en, input read_en, input adress, input write_data, output read_data);

endinterface

// File: rtl/synchronizer.sv
// Two-flop synchronizer for a single asynchronous input; RESET_VAL matches
// the idle level of the line so reset cannot fake an edge.
module synchronizer #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic sync_p0;
    logic sync_p1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0 <= RESET_VAL;
            sync_p1 <= RESET_VAL;
        end else begin
            sync_p0 <= d;
            sync_p1 <= sync_p0;
        end
    end

    assign q = sync_p1;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, shifts out one command
// frame on device-generated clocks, samples the ACK and raises an interrupt.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter logic [15:0] BASE_ADDRESS   = 16'h280,
    parameter int          INHIBIT_CYCLES = 5000,
    parameter int          TIMEOUT_CYCLES = 750000
) (
    input  logic            clk,
    input  logic            reset,
    io_bus_interface.slave  io_bus,
    input  logic            ps2_clk,
    input  logic            ps2_data,
    output logic            ps2_clk_oe,
    output logic            ps2_data_oe,
    output logic            tx_interrupt
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES);

    state_t             state;
    logic [7:0]         tx_byte;
    logic [3:0]         bit_index;
    logic [INH_W-1:0]   inhibit_cnt;
    logic [TO_W-1:0]    timeout_cnt;
    logic               nak;
    logic               timeout;
    logic               overrun;
    logic               clk_s;
    logic               data_s;
    logic               clk_s_p2;
    logic               fall;
    logic               is_data;
    logic               is_status;
    logic               wr_data;
    logic               next_bit_oe;
    logic [3:0]         status;
    logic               unused_wr_hi;

    synchronizer #(.RESET_VAL(1'b1)) u_sync_clk (
        .clk   (clk),
        .reset (reset),
        .d     (ps2_clk),
        .q     (clk_s)
    );

    synchronizer #(.RESET_VAL(1'b1)) u_sync_data (
        .clk   (clk),
        .reset (reset),
        .d     (ps2_data),
        .q     (data_s)
    );

    assign fall      = clk_s_p2 & ~clk_s;
    assign is_data   = (io_bus.adress == BASE_ADDRESS + REG_TX_DATA);
    assign is_status = (io_bus.adress == BASE_ADDRESS + REG_STATUS);
    assign wr_data   = io_bus.write_en & is_data;

    assign unused_wr_hi = ^io_bus.write_data[31:8];

    assign status[STAT_BUSY]    = (state != IDLE);
    assign status[STAT_NAK]     = nak;
    assign status[STAT_TIMEOUT] = timeout;
    assign status[STAT_OVERRUN] = overrun;

    // Indices 0..7 carry data, 8 carries odd parity (driven low when parity is 0), 9 is the released stop bit.
    always_comb begin
        next_bit_oe = 1'b0;
        if (bit_index < 4'd8)
            next_bit_oe = ~tx_byte[bit_index[2:0]];
        else if (bit_index == 4'd8)
            next_bit_oe = ^tx_byte;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            tx_byte          <= '0;
            bit_index        <= '0;
            inhibit_cnt      <= '0;
            timeout_cnt      <= '0;
            nak              <= 1'b0;
            timeout          <= 1'b0;
            overrun          <= 1'b0;
            clk_s_p2         <= 1'b1;
            ps2_clk_oe       <= 1'b0;
            ps2_data_oe      <= 1'b0;
            tx_interrupt     <= 1'b0;
            io_bus.read_data <= '0;
        end else begin
            clk_s_p2     <= clk_s;
            tx_interrupt <= 1'b0;

            if (io_bus.read_en && (is_status || is_data))
                io_bus.read_data <= is_status ? {28'b0, status} : 32'b0;

            if (wr_data && state != IDLE)
                overrun <= 1'b1;

            case (state)
                IDLE: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    if (wr_data) begin
                        tx_byte     <= io_bus.write_data[7:0];
                        nak         <= 1'b0;
                        timeout     <= 1'b0;
                        overrun     <= 1'b0;
                        inhibit_cnt <= INH_W'(INHIBIT_CYCLES - 1);
                        ps2_clk_oe  <= 1'b1;
                        state       <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (inhibit_cnt == '0) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b1;
                        state       <= START;
                    end else begin
                        inhibit_cnt <= inhibit_cnt - INH_W'(1);
                    end
                end
                START: begin
                    timeout_cnt <= TO_W'(TIMEOUT_CYCLES - 1);
                    bit_index   <= '0;
                    state       <= SHIFT;
                end
                SHIFT, ACK, WAIT_RELEASE: begin
                    // Expiry wins over any edge seen in the same cycle.
                    if (timeout_cnt == '0) begin
                        ps2_clk_oe   <= 1'b0;
                        ps2_data_oe  <= 1'b0;
                        timeout      <= 1'b1;
                        tx_interrupt <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        timeout_cnt <= timeout_cnt - TO_W'(1);
                        if (state == SHIFT && fall) begin
                            ps2_data_oe <= next_bit_oe;
                            bit_index   <= bit_index + 4'd1;
                            if (bit_index == 4'd9)
                                state <= ACK;
                        end else if (state == ACK && fall) begin
                            nak   <= data_s;
                            state <= WAIT_RELEASE;
                        end else if (state == WAIT_RELEASE && clk_s && data_s) begin
                            tx_interrupt <= 1'b1;
                            state        <= IDLE;
                        end
                    end
                end
                default: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule
